// File: rtl/keypad_pkg.sv
// Shared types, key map and key encoder for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN   = 2'd0,
      SETTLE = 2'd1,
      LOCK   = 2'd2
   } statetype;

   // Indexed [row][column], rows top to bottom.
   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Lowest active row index wins when several rows are down.
   function automatic logic [3:0] encode_key(input logic [3:0] row_onehot,
                                             input logic [1:0] col_idx);
      logic [3:0] v_hex;
      v_hex = 4'h0;
      for (int r = 3; r >= 0; r--) begin
         if (row_onehot[r]) v_hex = KEY_MAP[r][col_idx];
      end
      return v_hex;
   endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module row_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_row_raw,
   output logic [3:0] o_row_sync
);

   logic [3:0] r_stage1;
   logic [3:0] r_stage2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stage1 <= 4'b1111;
         r_stage2 <= 4'b1111;
      end else begin
         r_stage1 <= i_row_raw;
         r_stage2 <= r_stage1;
      end
   end

   assign o_row_sync = r_stage2;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates active-low columns, locks on a press, encodes the key,
// and resumes scanning only after SCAN_DIV consecutive idle cycles.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 1200,
   parameter int unsigned SETTLE_CYC = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_raw,
   output logic [3:0] col,
   output logic [3:0] q_row_keys,
   output logic [1:0] col_idx,
   output logic [3:0] key_hex,
   output logic       key_valid
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV) + 1;
   localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   statetype         r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [1:0]       r_col_idx, w_col_idx_next;
   logic [3:0]       r_key_hex, w_key_hex_next;
   logic             r_key_valid, w_key_valid_next;
   logic [3:0]       r_q_row_keys, w_q_row_keys_next;
   logic [3:0]       w_row_sync;
   logic [3:0]       w_row_act;

   row_sync u_row_sync (
      .clk        (clk),
      .reset      (reset),
      .i_row_raw  (row_raw),
      .o_row_sync (w_row_sync)
   );

   assign w_row_act = ~w_row_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= SETTLE;
         r_cnt        <= '0;
         r_col_idx    <= 2'd0;
         r_key_hex    <= 4'h0;
         r_key_valid  <= 1'b0;
         r_q_row_keys <= 4'b0000;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_col_idx    <= w_col_idx_next;
         r_key_hex    <= w_key_hex_next;
         r_key_valid  <= w_key_valid_next;
         r_q_row_keys <= w_q_row_keys_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_col_idx_next    = r_col_idx;
      w_key_hex_next    = r_key_hex;
      w_key_valid_next  = 1'b0;
      // Sync data seen during SETTLE still belongs to the previous column.
      w_q_row_keys_next = (r_state == SETTLE) ? 4'b0000 : w_row_act;

      unique case (r_state)
         SETTLE: begin
            if (r_cnt == SETTLE_LAST) begin
               w_state_next = SCAN;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         SCAN: begin
            // A press wins over a rotation due in the same cycle.
            if (|w_row_act) begin
               w_state_next     = LOCK;
               w_cnt_next       = '0;
               w_key_hex_next   = encode_key(w_row_act, r_col_idx);
               w_key_valid_next = 1'b1;
            end else if (r_cnt == SCAN_LAST) begin
               w_state_next   = SETTLE;
               w_cnt_next     = '0;
               w_col_idx_next = r_col_idx + 2'd1;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         LOCK: begin
            if (|w_row_act) begin
               w_cnt_next = '0;
            end else if (r_cnt == SCAN_LAST) begin
               w_state_next = SETTLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = SETTLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign col        = ~(4'b0001 << r_col_idx);
   assign col_idx    = r_col_idx;
   assign key_hex    = r_key_hex;
   assign key_valid  = r_key_valid;
   assign q_row_keys = r_q_row_keys;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed, table-driven bench for keypad_scanner with SCAN_DIV=8, SETTLE_CYC=3.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_raw;
   logic [3:0] col;
   logic [3:0] q_row_keys;
   logic [1:0] col_idx;
   logic [3:0] key_hex;
   logic       key_valid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV   (8),
      .SETTLE_CYC (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .row_raw    (row_raw),
      .col        (col),
      .q_row_keys (q_row_keys),
      .col_idx    (col_idx),
      .key_hex    (key_hex),
      .key_valid  (key_valid)
   );

   // One segment: hold row for n cycles, expecting the same outputs after each edge.
   typedef struct {
      logic [3:0] row;
      int         n;
      logic [3:0] col;
      logic [1:0] idx;
      logic [3:0] q;
      logic       kv;
      logic [3:0] hex;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] row, int n, logic [3:0] c, logic [1:0] idx,
                               logic [3:0] q, logic kv, logic [3:0] hex);
      vec_t v;
      v.row = row; v.n = n; v.col = c; v.idx = idx; v.q = q; v.kv = kv; v.hex = hex;
      return v;
   endfunction

   task automatic chk(string what, int seg, int cyc, logic [3:0] got, logic [3:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s seg%0d cyc%0d got %h want %h", what, seg, cyc, got, want);
      end
   endtask

   task automatic check_all(int seg, int cyc, vec_t v);
      chk("col",        seg, cyc, col,                 v.col);
      chk("col_idx",    seg, cyc, {2'b00, col_idx},    {2'b00, v.idx});
      chk("q_row_keys", seg, cyc, q_row_keys,          v.q);
      chk("key_valid",  seg, cyc, {3'b000, key_valid}, {3'b000, v.kv});
      chk("key_hex",    seg, cyc, key_hex,             v.hex);
   endtask

   task automatic run_seg(int seg, vec_t v);
      row_raw = v.row;
      for (int c = 0; c < v.n; c++) begin
         @(posedge clk);
         @(negedge clk);
         check_all(seg, c, v);
      end
   endtask

   initial begin
      reset   = 1'b1;
      row_raw = 4'b1111;

      // Idle scan: 3 settle + 8 scan cycles per column, wrapping 3 -> 0.
      vecs.push_back(mk(4'b1111, 10, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111, 11, 4'b1101, 2'd1, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111, 11, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111, 11, 4'b0111, 2'd3, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111,  1, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111, 10, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111, 11, 4'b1101, 2'd1, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1111,  4, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h0));
      // Press r1 on column 2 -> "6", lock on third edge, held past the rotation point.
      vecs.push_back(mk(4'b1101,  2, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h0));
      vecs.push_back(mk(4'b1101,  1, 4'b1011, 2'd2, 4'h2, 1'b1, 4'h6));
      vecs.push_back(mk(4'b1101,  5, 4'b1011, 2'd2, 4'h2, 1'b0, 4'h6));
      // 5-cycle bounce: lock held, no second pulse.
      vecs.push_back(mk(4'b1111,  2, 4'b1011, 2'd2, 4'h2, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1111,  3, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1101,  2, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1101,  3, 4'b1011, 2'd2, 4'h2, 1'b0, 4'h6));
      // Qualified release: SETTLE and SCAN on column 2, then column 3.
      vecs.push_back(mk(4'b1111,  2, 4'b1011, 2'd2, 4'h2, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1111, 18, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1111,  1, 4'b0111, 2'd3, 4'h0, 1'b0, 4'h6));
      // Two rows on column 1 -> lowest row wins ("8"), full vector passed through.
      vecs.push_back(mk(4'b1111, 10, 4'b0111, 2'd3, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1111, 11, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b1111,  4, 4'b1101, 2'd1, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b0011,  2, 4'b1101, 2'd1, 4'h0, 1'b0, 4'h6));
      vecs.push_back(mk(4'b0011,  1, 4'b1101, 2'd1, 4'hC, 1'b1, 4'h8));
      vecs.push_back(mk(4'b0011,  2, 4'b1101, 2'd1, 4'hC, 1'b0, 4'h8));
      // Release, scan on to column 3 and lock on "D".
      vecs.push_back(mk(4'b1111,  2, 4'b1101, 2'd1, 4'hC, 1'b0, 4'h8));
      vecs.push_back(mk(4'b1111, 18, 4'b1101, 2'd1, 4'h0, 1'b0, 4'h8));
      vecs.push_back(mk(4'b1111, 11, 4'b1011, 2'd2, 4'h0, 1'b0, 4'h8));
      vecs.push_back(mk(4'b1111,  4, 4'b0111, 2'd3, 4'h0, 1'b0, 4'h8));
      vecs.push_back(mk(4'b0111,  2, 4'b0111, 2'd3, 4'h0, 1'b0, 4'h8));
      vecs.push_back(mk(4'b0111,  1, 4'b0111, 2'd3, 4'h8, 1'b1, 4'hD));
      vecs.push_back(mk(4'b0111,  2, 4'b0111, 2'd3, 4'h8, 1'b0, 4'hD));

      repeat (3) @(negedge clk);
      check_all(-1, 0, mk(4'b1111, 0, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h0));
      reset = 1'b0;

      foreach (vecs[i]) run_seg(i, vecs[i]);

      // Reset while locked on "D": outputs return at once, scan restarts from column 0.
      reset   = 1'b1;
      row_raw = 4'b1111;
      #1;
      check_all(90, 0, mk(4'b1111, 0, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h0));
      @(negedge clk);
      reset = 1'b0;
      run_seg(91, mk(4'b1111, 10, 4'b1110, 2'd0, 4'h0, 1'b0, 4'h0));
      run_seg(92, mk(4'b1111,  1, 4'b1101, 2'd1, 4'h0, 1'b0, 4'h0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 keypad columns one-hot active-low and samples the active-low row lines through a synchronizer.
- Presents an active-high row vector for the currently driven column to the debouncer, on the debouncer's q_row_keys input.
- Freezes on the driven column while a key is down and encodes the key to a hex code.
- Resumes rotating the columns only after a qualified release.

Parameters:
SCAN_DIV, 1200, clock cycles each column is driven while scanning; also the release-qualification length; must be >= 8.
SETTLE_CYC, 3, cycles after a column change during which row data is masked; must be >= 3 (2 sync stages + 1).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
row_raw  input  4  raw keypad rows, active-low (pulled up), asynchronous to clk
col  output  4  column drive, one-hot active-low, 4'b1110 = column 0
q_row_keys  output  4  synchronized active-high row vector for the driven column; 0 while masked
col_idx  output  2  index of the driven column
key_hex  output  4  encoded key, latched on lock entry
key_valid  output  1  one-cycle pulse on lock entry

Behaviour:
- Asynchronous, active-high reset; on reset:
  - col=4'b1110, col_idx=0, q_row_keys=0, key_hex=0, key_valid=0.
  - state=SETTLE, counter=0, sync flops=4'b1111.
- Synchronizer: two flops on row_raw. row_act = ~stage2 (active-high).
- q_row_keys = row_act in SCAN and LOCK; 4'b0000 in SETTLE (registered, 1-cycle delay from row_act).
- State SETTLE:
  - Counter counts 0..SETTLE_CYC-1, then goes to SCAN with counter=0.
  - Rows are ignored because sync data belongs to the previous column.
- State SCAN:
  - If row_act != 0: go to LOCK next cycle. Latch col_idx and the lowest-index active row. key_hex is registered from the key map. key_valid=1 for exactly that one cycle.
  - Else, when counter == SCAN_DIV-1: col_idx <= col_idx+1 (3 wraps to 0), col updates in the same cycle, counter=0, go to SETTLE.
  - Else counter++.
  - A press takes priority over a same-cycle column rotation.
- State LOCK:
  - col and col_idx are frozen; key_hex is held.
  - Counter clears on any cycle with row_act != 0 and increments while row_act == 0.
  - When the counter reaches SCAN_DIV-1 (SCAN_DIV consecutive zero cycles), go to SETTLE on the same column with counter=0.
  - Bounces shorter than SCAN_DIV keep the lock and do not re-pulse key_valid.
- Key map (row r, column c), rows top to bottom:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Multiple rows active at lock entry: the lowest row index wins for key_hex; q_row_keys still passes the full vector.
- A second key in another column while locked is ignored until release.
- Reset asserted mid-LOCK or mid-SETTLE: immediate return to reset values and resumption from column 0.
- Counter width: $clog2(SCAN_DIV)+1 bits; no overflow is possible.

Decomposition:
- Shared package keypad_pkg:
  - statetype enum {SCAN, SETTLE, LOCK}, logic [1:0].
  - Constant 4x4 key map array.
  - Function encode_key(row_onehot, col_idx) returning logic [3:0].
- One sub-module: row_sync, a 4-bit two-flop synchronizer with async reset to 4'b1111.
- The scan/release counter is internal to keypad_scanner, not a separate divider instance.

Test Plan:
1. Reset, SCAN_DIV=8, SETTLE_CYC=3, rows idle (4'b1111) -> col sequence 1110, 1101, 1011, 0111, 1110; each column lasts 3+8 cycles; key_valid never asserts; q_row_keys=0.
2. Press r1 while column 2 is driven (row_raw=4'b1101 in SCAN at col_idx=2) -> LOCK 3 cycles after the row edge; col stays 1011; key_valid pulses once; key_hex=4'h6; q_row_keys=4'b0010.
3. While locked on "6", release for 5 cycles then re-press (bounce < SCAN_DIV) -> lock held; no second key_valid; key_hex stays 6.
4. Release for 8+ consecutive cycles -> SETTLE on column 2, then SCAN resumes with col=1011; the next column is 3.
5. Press r2 and r3 together on column 1 (row_raw=4'b0011) -> key_hex=4'h8 (lowest row); q_row_keys=4'b1100.
6. Assert reset while locked on "D" (r3, c3) -> same edge: col=1110, col_idx=0, key_hex=0, key_valid=0; scanning restarts from column 0 after SETTLE.
